mult_div_unit: RTL and testbench

Iterative 32-bit multiply/divide unit for the EX stage of the 5-stage MIPS pipeline. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO commands, computes over 33 cycles with a Busy/Done handshake, and holds the architectural HI and LO registers. Hi and Lo feed the downstream 32-bit 2:1 mux that selects the MFHI/MFLO result for writeback. The hazard unit stalls on Busy.

---
 rtl/mult_div_unit.sv | 115 +++++++++++
 tb/tb_mult_div_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-bit MIPS multiply/divide unit holding the HI/LO registers
module mult_div_unit (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_div_by_zero,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  state_t      r_state;
  logic [4:0]  r_count;
  logic        r_div;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_zero;
  logic [31:0] r_a;
  logic [31:0] r_x;
  logic [31:0] r_y;
  logic [31:0] r_p;
  logic        w_sgn;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [32:0] w_sum;
  logic [32:0] w_shift;
  logic        w_ge;
  logic [31:0] w_diff;
  logic [63:0] w_prod;
  logic [63:0] w_prod_n;
  logic [31:0] w_q;
  logic [31:0] w_r;
  logic [31:0] w_hi;
  logic [31:0] w_lo;
  // operand magnitudes: two's complement negation maps 0x80000000 onto magnitude 2^31
  assign w_sgn   = ~i_op[0];
  assign w_mag_a = (w_sgn & i_a[31]) ? -i_a : i_a;
  assign w_mag_b = (w_sgn & i_b[31]) ? -i_b : i_b;
  // multiply step: r_x is the multiplier shifting out LSB-first while product bits shift in from the top
  assign w_sum   = {1'b0, r_p} + {1'b0, r_x[0] ? r_y : 32'd0};
  // divide step: restoring shift-subtract; remainder stays below the divisor so 32 bits hold it
  assign w_shift = {r_p, r_x[31]};
  assign w_ge    = w_shift >= {1'b0, r_y};
  assign w_diff  = w_shift[31:0] - r_y;
  // sign fix-up of the finished magnitudes
  assign w_prod   = {r_p, r_x};
  assign w_prod_n = r_neg_q ? -w_prod : w_prod;
  assign w_q      = r_neg_q ? -r_x : r_x;
  assign w_r      = r_neg_r ? -r_p : r_p;
  assign w_hi     = r_div ? (r_zero ? r_a : w_r) : w_prod_n[63:32];
  assign w_lo     = r_div ? (r_zero ? 32'hFFFF_FFFF : w_q) : w_prod_n[31:0];
  // control FSM, datapath iteration and architectural HI/LO with registered handshake outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= IDLE;
      r_count       <= '0;
      r_div         <= 1'b0;
      r_neg_q       <= 1'b0;
      r_neg_r       <= 1'b0;
      r_zero        <= 1'b0;
      r_a           <= '0;
      r_x           <= '0;
      r_y           <= '0;
      r_p           <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_div_by_zero <= 1'b0;
      o_hi          <= '0;
      o_lo          <= '0;
    end else begin
      o_done        <= 1'b0;
      o_div_by_zero <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start && !i_op[2]) begin
            r_state <= RUN;
            o_busy  <= 1'b1;
            r_count <= '0;
            r_div   <= i_op[1];
            r_neg_q <= w_sgn & (i_a[31] ^ i_b[31]);
            r_neg_r <= w_sgn & i_a[31];
            r_zero  <= i_op[1] & (i_b == 32'd0);
            r_a     <= i_a;
            r_x     <= i_op[1] ? w_mag_a : w_mag_b;
            r_y     <= i_op[1] ? w_mag_b : w_mag_a;
            r_p     <= '0;
          end else if (i_start && i_op == 3'b100) begin
            o_hi <= i_a;
          end else if (i_start && i_op == 3'b101) begin
            o_lo <= i_a;
          end
        end
        RUN: begin
          r_p     <= r_div ? (w_ge ? w_diff : w_shift[31:0]) : w_sum[32:1];
          r_x     <= r_div ? {r_x[30:0], w_ge} : {w_sum[0], r_x[31:1]};
          r_count <= r_count + 5'd1;
          if (r_count == 5'd31) r_state <= FINISH;
        end
        FINISH: begin
          r_state       <= IDLE;
          o_busy        <= 1'b0;
          o_done        <= 1'b1;
          o_div_by_zero <= r_zero;
          o_hi          <= w_hi;
          o_lo          <= w_lo;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed self-checking bench for mult_div_unit
module tb_mult_div_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        o_busy;
  logic        o_done;
  logic        o_div_by_zero;
  logic [31:0] o_hi;
  logic [31:0] o_lo;
  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  mult_div_unit dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_start(start),
    .i_op(op),
    .i_a(a),
    .i_b(b),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_div_by_zero(o_div_by_zero),
    .o_hi(o_hi),
    .o_lo(o_lo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_result(input string tag, input logic [31:0] eh, input logic [31:0] el,
                             input logic ed, input bit noise);
    int n = 0;
    while (o_busy && n < 40) begin
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        op = 3'($urandom_range(0, 7));
        a = $urandom;
        b = $urandom;
      end
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, " busy_cycles"}, 64'(n), 64'd33);
    chk({tag, " done"}, 64'(o_done), 64'd1);
    chk({tag, " dbz"}, 64'(o_div_by_zero), 64'(ed));
    chk({tag, " hi"}, 64'(o_hi), 64'(eh));
    chk({tag, " lo"}, 64'(o_lo), 64'(el));
  endtask

  task automatic done_low(input string tag);
    @(negedge clk);
    chk({tag, " done_low"}, 64'(o_done), 64'd0);
    chk({tag, " dbz_low"}, 64'(o_div_by_zero), 64'd0);
  endtask

  initial begin
    int dp;
    repeat (2) @(negedge clk);
    chk("rst busy", 64'(o_busy), 64'd0);
    chk("rst done", 64'(o_done), 64'd0);
    chk("rst dbz", 64'(o_div_by_zero), 64'd0);
    chk("rst hi", 64'(o_hi), 64'd0);
    chk("rst lo", 64'(o_lo), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(3'b000, 32'hFFFF_FFFD, 32'd7);
    wait_result("mult_m3x7", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0);
    done_low("mult_m3x7");

    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_result("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
    issue(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("b2b done_low", 64'(o_done), 64'd0);
    chk("b2b busy", 64'(o_busy), 64'd1);
    wait_result("mult_m1xm1", 32'h0, 32'h1, 1'b0, 1'b0);
    done_low("mult_m1xm1");

    issue(3'b010, 32'hFFFF_FFF9, 32'd2);
    wait_result("div_m7d2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
    done_low("div_m7d2");
    issue(3'b011, 32'd100, 32'd7);
    wait_result("divu_100d7", 32'd2, 32'd14, 1'b0, 1'b0);
    done_low("divu_100d7");
    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_result("div_min_m1", 32'h0, 32'h8000_0000, 1'b0, 1'b0);
    done_low("div_min_m1");
    issue(3'b011, 32'h0000_1234, 32'd0);
    wait_result("divu_by0", 32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 1'b0);
    done_low("divu_by0");

    start = 1'b1;
    op = 3'b100;
    a = 32'hDEAD_BEEF;
    @(negedge clk);
    op = 3'b101;
    a = 32'hCAFE_F00D;
    chk("mthi hi", 64'(o_hi), 64'hDEAD_BEEF);
    chk("mthi lo", 64'(o_lo), 64'hFFFF_FFFF);
    chk("mthi busy", 64'(o_busy), 64'd0);
    chk("mthi done", 64'(o_done), 64'd0);
    @(negedge clk);
    start = 1'b0;
    chk("mtlo lo", 64'(o_lo), 64'hCAFE_F00D);
    chk("mtlo hi", 64'(o_hi), 64'hDEAD_BEEF);
    chk("mtlo busy", 64'(o_busy), 64'd0);
    chk("mtlo done", 64'(o_done), 64'd0);

    issue(3'b110, 32'h1111_1111, 32'h2222_2222);
    issue(3'b111, 32'h3333_3333, 32'h4444_4444);
    chk("nop hi", 64'(o_hi), 64'hDEAD_BEEF);
    chk("nop lo", 64'(o_lo), 64'hCAFE_F00D);
    chk("nop busy", 64'(o_busy), 64'd0);
    chk("nop done", 64'(o_done), 64'd0);

    issue(3'b011, 32'd1003, 32'd10);
    wait_result("divu_noise", 32'd3, 32'd100, 1'b0, 1'b1);
    done_low("divu_noise");

    issue(3'b001, 32'h1234_5678, 32'd9);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst busy", 64'(o_busy), 64'd0);
    chk("midrst hi", 64'(o_hi), 64'd0);
    chk("midrst lo", 64'(o_lo), 64'd0);
    dp = 0;
    repeat (45) begin
      @(negedge clk);
      if (o_done) dp++;
    end
    chk("midrst done_pulses", 64'(dp), 64'd0);

    rst = 1'b1;
    start = 1'b1;
    op = 3'b001;
    a = 32'd5;
    b = 32'd6;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    chk("rst_vs_start busy0", 64'(o_busy), 64'd0);
    @(negedge clk);
    chk("rst_vs_start busy1", 64'(o_busy), 64'd0);

    issue(3'b001, 32'd5, 32'd6);
    wait_result("multu_5x6", 32'd0, 32'd30, 1'b0, 1'b0);
    done_low("multu_5x6");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
